// File: rtl/mpu_6050_pkg.sv
// Shared definitions for the MPU-6050 command sequencer: command codes,
// list lengths and FSM state encodings.
// Build option: MPU_6050_SEQ_TEMP_EN adds the TEMP read to the periodic read list.
package mpu_6050_pkg;

    localparam logic [3:0] CMD_NOP          = 4'd0;
    localparam logic [3:0] CMD_WHO_AM_I     = 4'd1;
    localparam logic [3:0] CMD_PWR_MGMT_1   = 4'd2;
    localparam logic [3:0] CMD_SMPLRT_DIV   = 4'd3;
    localparam logic [3:0] CMD_CONFIG       = 4'd4;
    localparam logic [3:0] CMD_GYRO_CONFIG  = 4'd5;
    localparam logic [3:0] CMD_ACCEL_CONFIG = 4'd6;
    localparam logic [3:0] CMD_ACCEL        = 4'd8;
    localparam logic [3:0] CMD_TEMP         = 4'd9;
    localparam logic [3:0] CMD_GYRO         = 4'd10;

    localparam int INIT_LEN = 6;
`ifdef MPU_6050_SEQ_TEMP_EN
    localparam int READ_LEN = 3;
`else
    localparam int READ_LEN = 2;
`endif

    // Last valid list index, pre-sized to the index register width
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [2:0] READ_LAST = 3'(READ_LEN - 1);

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ISSUE     = 3'd1;
    localparam state_t ST_WAIT_DONE = 3'd2;
    localparam state_t ST_RELEASE   = 3'd3;
    localparam state_t ST_NEXT      = 3'd4;
    localparam state_t ST_WAIT_TICK = 3'd5;
    localparam state_t ST_RETRY     = 3'd6;
    localparam state_t ST_FAULT     = 3'd7;

endpackage

// File: rtl/mpu_smpl_timer.sv
// Sample-period timer: while enabled, emits a one-cycle tick every PERIOD
// cycles. Disabling it returns the counter to zero.
module mpu_smpl_timer #(
    parameter int PERIOD = 500_000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic I_EN,
    output logic O_TICK
);

    localparam int CW = $clog2(PERIOD + 1);

    logic [CW-1:0] cnt;

    // Period counter with registered tick on wrap
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt    <= '0;
            O_TICK <= 1'b0;
        end else if (!I_EN) begin
            cnt    <= '0;
            O_TICK <= 1'b0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt    <= '0;
            O_TICK <= 1'b1;
        end else begin
            cnt    <= cnt + CW'(1);
            O_TICK <= 1'b0;
        end
    end

endmodule

// File: rtl/mpu_6050_sequencer.sv
// Command sequencer in front of the MPU-6050 top: runs the init list once,
// then the sensor read list on every sample tick, with a 4-phase handshake,
// timeout/error retries, a sticky fault and an overrun counter.
// Build option: MPU_6050_SEQ_TEMP_EN selects the 8,9,10 read list (else 8,10).
module mpu_6050_sequencer #(
    parameter int FPGA_CLK    = 50_000_000,
    parameter int SMPL_RATE   = 100,
    parameter int TIMEOUT_CYC = 100_000,
    parameter int MAX_RETRY   = 3,
    parameter int ADDR_ROM_SZ = 4,
    parameter int FL_SZ       = 8
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_START,
    input  logic [FL_SZ-1:0]       I_FL,
    input  logic                   I_ERR,
    input  logic                   I_ACK_FL,
    output logic [ADDR_ROM_SZ-1:0] O_COMM,
    output logic                   O_INIT_DONE,
    output logic                   O_SMPL_STB,
    output logic                   O_FAULT,
    output logic [4:0]             O_CNT_OVR
);

    import mpu_6050_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state;
    logic [2:0]    idx;
    logic          in_init;
    logic          start_q;
    logic [1:0]    err_s;
    logic [1:0]    err_d;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_inc;
    logic          pending;
    logic          tick;
    logic          fl_nz;
    logic          err_edge;
    logic          start_rise;
    logic          list_last;
    logic          read_active;

    // Command ROMs for the init list and the periodic read list
    function automatic logic [3:0] list_code(input logic init, input logic [2:0] i);
        logic [3:0] c;
        c = CMD_NOP;
        if (init) begin
            case (i)
                3'd0: c = CMD_WHO_AM_I;
                3'd1: c = CMD_PWR_MGMT_1;
                3'd2: c = CMD_SMPLRT_DIV;
                3'd3: c = CMD_CONFIG;
                3'd4: c = CMD_GYRO_CONFIG;
                3'd5: c = CMD_ACCEL_CONFIG;
                default: c = CMD_NOP;
            endcase
        end else begin
            case (i)
`ifdef MPU_6050_SEQ_TEMP_EN
                3'd0: c = CMD_ACCEL;
                3'd1: c = CMD_TEMP;
                3'd2: c = CMD_GYRO;
`else
                3'd0: c = CMD_ACCEL;
                3'd1: c = CMD_GYRO;
`endif
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    assign fl_nz       = (I_FL != '0);
    assign err_edge    = |(err_s & ~err_d);
    assign start_rise  = I_START & ~start_q;
    assign retry_inc   = retry + RW'(1);
    assign list_last   = in_init ? (idx == INIT_LAST) : (idx == READ_LAST);
    assign read_active = O_INIT_DONE && (state != ST_IDLE) &&
                         (state != ST_WAIT_TICK) && (state != ST_FAULT);

    mpu_smpl_timer #(
        .PERIOD(FPGA_CLK / SMPL_RATE)
    ) u_smpl_timer (
        .CLK   (CLK),
        .RST_n (RST_n),
        .I_EN  (O_INIT_DONE),
        .O_TICK(tick)
    );

    // Sequencer FSM, handshake, retry/timeout and overrun bookkeeping
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            in_init     <= 1'b1;
            start_q     <= 1'b1;
            err_s       <= '0;
            err_d       <= '0;
            tcnt        <= '0;
            retry       <= '0;
            pending     <= 1'b0;
            O_COMM      <= '0;
            O_INIT_DONE <= 1'b0;
            O_SMPL_STB  <= 1'b0;
            O_FAULT     <= 1'b0;
            O_CNT_OVR   <= '0;
        end else begin
            start_q    <= I_START;
            err_s      <= {I_ERR, I_ACK_FL};
            err_d      <= err_s;
            O_SMPL_STB <= 1'b0;
            if (!I_START) begin
                state       <= ST_IDLE;
                idx         <= '0;
                in_init     <= 1'b1;
                tcnt        <= '0;
                retry       <= '0;
                pending     <= 1'b0;
                O_COMM      <= '0;
                O_INIT_DONE <= 1'b0;
                O_FAULT     <= 1'b0;
            end else begin
                if (tick && read_active) begin
                    if (!pending) begin
                        pending <= 1'b1;
                    end else if (O_CNT_OVR != 5'd31) begin
                        O_CNT_OVR <= O_CNT_OVR + 5'd1;
                    end
                end
                case (state)
                    ST_IDLE: begin
                        if (start_rise) begin
                            idx     <= '0;
                            in_init <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        O_COMM <= ADDR_ROM_SZ'(list_code(in_init, idx));
                        tcnt   <= '0;
                        state  <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        if (err_edge || (tcnt == TW'(TIMEOUT_CYC - 1))) begin
                            O_COMM <= '0;
                            state  <= ST_RETRY;
                        end else if (fl_nz) begin
                            O_COMM <= '0;
                            state  <= ST_RELEASE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (!fl_nz) state <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        retry <= '0;
                        if (list_last) begin
                            idx   <= '0;
                            state <= ST_WAIT_TICK;
                            if (in_init) begin
                                O_INIT_DONE <= 1'b1;
                                in_init     <= 1'b0;
                            end else begin
                                O_SMPL_STB <= 1'b1;
                            end
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_ISSUE;
                        end
                    end
                    ST_WAIT_TICK: begin
                        if (tick || pending) begin
                            pending <= 1'b0;
                            idx     <= '0;
                            state   <= ST_ISSUE;
                        end
                    end
                    ST_RETRY: begin
                        if (!fl_nz) begin
                            retry <= retry_inc;
                            if (retry_inc > RW'(MAX_RETRY)) begin
                                O_FAULT <= 1'b1;
                                state   <= ST_FAULT;
                            end else begin
                                state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_FAULT: begin
                        O_COMM <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpu_6050_sequencer.sv
// Directed testbench for mpu_6050_sequencer with a behavioural responder
// standing in for the MPU-6050 top. Honours MPU_6050_SEQ_TEMP_EN.
module tb_mpu_6050_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] fl;
    logic       err;
    logic       ack_fl;
    logic [3:0] comm;
    logic       init_done;
    logic       smpl_stb;
    logic       fault;
    logic [4:0] cnt_ovr;

    int total;
    int bad;
    int cyc;

`ifdef MPU_6050_SEQ_TEMP_EN
    localparam int RL = 3;
`else
    localparam int RL = 2;
`endif
    int exp_read[3];

    // Responder knobs
    int resp_delay;
    int resp_hold;
    int hold_read;
    int ignore_code;

    // Monitor logs
    int log_code[$];
    int log_cyc[$];
    int stb_cyc[$];
    int stb_hi;

    mpu_6050_sequencer #(
        .FPGA_CLK   (1_000_000),
        .SMPL_RATE  (1000),
        .TIMEOUT_CYC(100),
        .MAX_RETRY  (3),
        .ADDR_ROM_SZ(4),
        .FL_SZ      (8)
    ) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .I_START    (start),
        .I_FL       (fl),
        .I_ERR      (err),
        .I_ACK_FL   (ack_fl),
        .O_COMM     (comm),
        .O_INIT_DONE(init_done),
        .O_SMPL_STB (smpl_stb),
        .O_FAULT    (fault),
        .O_CNT_OVR  (cnt_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: answers a command after resp_delay cycles, drops the flag
    // after the NOP has been held for the hold time
    initial begin
        int phase;
        int rcnt;
        int rcode;
        int hold;
        phase = 0;
        rcnt  = 0;
        rcode = 0;
        fl    = 8'h00;
        forever begin
            @(posedge clk); #1;
            case (phase)
                0: if (comm != 4'd0 && int'(comm) != ignore_code) begin
                    phase = 1; rcnt = 0; rcode = int'(comm);
                end
                1: if (comm == 4'd0) begin
                    phase = 0;
                end else begin
                    rcnt++;
                    if (rcnt >= resp_delay) begin fl = 8'h01; phase = 2; end
                end
                2: if (comm == 4'd0) begin phase = 3; rcnt = 0; end
                default: begin
                    hold = (rcode >= 8) ? hold_read : resp_hold;
                    rcnt++;
                    if (rcnt >= hold) begin fl = 8'h00; phase = 0; end
                end
            endcase
        end
    end

    // Monitor: logs every new command issue and strobe with its cycle number
    initial begin
        logic [3:0] prev_comm;
        logic       prev_stb;
        prev_comm = 4'd0;
        prev_stb  = 1'b0;
        cyc       = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (comm != 4'd0 && comm != prev_comm) begin
                log_code.push_back(int'(comm));
                log_cyc.push_back(cyc);
            end
            prev_comm = comm;
            if (smpl_stb) begin
                stb_hi++;
                if (!prev_stb) stb_cyc.push_back(cyc);
            end
            prev_stb = smpl_stb;
        end
    end

    task automatic clear_logs();
        log_code.delete();
        log_cyc.delete();
        stb_cyc.delete();
        stb_hi = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; err = 1'b0; ack_fl = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (comm !== 4'd0) begin bad++; $display("[TB] FAIL reset_comm got=%0d want=0", comm); end
        total++; if (init_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_init_done got=%b want=0", init_done); end
        total++; if (smpl_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb got=%b want=0", smpl_stb); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b want=0", fault); end
        total++; if (cnt_ovr !== 5'd0) begin bad++; $display("[TB] FAIL reset_cnt_ovr got=%0d want=0", cnt_ovr); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_init_and_reads();
        bit ok;
        $display("[TB] init list and periodic reads");
        clear_logs();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #2;
        total++; if (comm !== 4'd0) begin bad++; $display("[TB] FAIL start_lat1 got=%0d want=0", comm); end
        @(posedge clk); #2;
        total++; if (comm !== 4'd1) begin bad++; $display("[TB] FAIL start_lat2 got=%0d want=1", comm); end
        ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #2;
            if (log_code.size() >= 6 + 2 * RL && stb_cyc.size() >= 2) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("[TB] FAIL reads_wait got=%0d issues want=%0d", log_code.size(), 6 + 2 * RL); end
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                total++; if (log_code[i] != i + 1) begin bad++; $display("[TB] FAIL init_code[%0d] got=%0d want=%0d", i, log_code[i], i + 1); end
            end
            for (int i = 1; i < 6; i++) begin
                total++; if (log_cyc[i] - log_cyc[i-1] != 25) begin bad++; $display("[TB] FAIL init_gap[%0d] got=%0d want=25", i, log_cyc[i] - log_cyc[i-1]); end
            end
            total++; if (init_done !== 1'b1) begin bad++; $display("[TB] FAIL init_done got=%b want=1", init_done); end
            for (int l = 0; l < 2; l++) begin
                for (int j = 0; j < RL; j++) begin
                    total++; if (log_code[6 + l * RL + j] != exp_read[j]) begin bad++; $display("[TB] FAIL read_code[%0d][%0d] got=%0d want=%0d", l, j, log_code[6 + l * RL + j], exp_read[j]); end
                end
            end
            total++; if (log_cyc[6 + RL] - log_cyc[6] != 1000) begin bad++; $display("[TB] FAIL list_period got=%0d want=1000", log_cyc[6 + RL] - log_cyc[6]); end
            total++; if (stb_cyc[0] - log_cyc[5 + RL] != 24) begin bad++; $display("[TB] FAIL stb_delay got=%0d want=24", stb_cyc[0] - log_cyc[5 + RL]); end
            total++; if (stb_cyc[1] - stb_cyc[0] != 1000) begin bad++; $display("[TB] FAIL stb_period got=%0d want=1000", stb_cyc[1] - stb_cyc[0]); end
            total++; if (stb_hi != stb_cyc.size()) begin bad++; $display("[TB] FAIL stb_width got=%0d want=%0d", stb_hi, stb_cyc.size()); end
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2;
        total++; if (init_done !== 1'b0 || comm !== 4'd0) begin bad++; $display("[TB] FAIL stop_idle got=%b/%0d want=0/0", init_done, comm); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_retry_fault();
        bit ok;
        int fcyc;
        int n2;
        $display("[TB] timeout retries into fault");
        ignore_code = 2;
        clear_logs();
        @(negedge clk); start = 1'b1;
        ok = 0; fcyc = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #2;
            if (fault === 1'b1) begin ok = 1; fcyc = cyc; break; end
        end
        total++; if (!ok) begin bad++; $display("[TB] FAIL fault_wait got=0 want=1"); end
        total++; if (comm !== 4'd0) begin bad++; $display("[TB] FAIL fault_comm got=%0d want=0", comm); end
        total++; if (log_code.size() != 5) begin bad++; $display("[TB] FAIL fault_issues got=%0d want=5", log_code.size()); end
        if (ok && log_code.size() == 5) begin
            n2 = 0;
            foreach (log_code[i]) if (log_code[i] == 2) n2++;
            total++; if (n2 != 4) begin bad++; $display("[TB] FAIL fault_cmd2_count got=%0d want=4", n2); end
            for (int i = 2; i < 5; i++) begin
                total++; if (log_cyc[i] - log_cyc[i-1] != 102) begin bad++; $display("[TB] FAIL retry_gap[%0d] got=%0d want=102", i, log_cyc[i] - log_cyc[i-1]); end
            end
            total++; if (fcyc - log_cyc[4] != 101) begin bad++; $display("[TB] FAIL fault_delay got=%0d want=101", fcyc - log_cyc[4]); end
        end
        repeat (300) @(posedge clk);
        #2;
        total++; if (fault !== 1'b1 || log_code.size() != 5) begin bad++; $display("[TB] FAIL fault_sticky got=%b/%0d want=1/5", fault, log_code.size()); end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2;
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL fault_clear got=%b want=0", fault); end
        ignore_code = 15;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ack_retry();
        bit ok;
        int targets[4];
        int exp_log[10];
        targets = '{3, 5, 5, 5};
        exp_log = '{1, 2, 3, 3, 4, 5, 5, 5, 5, 6};
        $display("[TB] NACK retries with counter reset");
        clear_logs();
        @(negedge clk); start = 1'b1;
        foreach (targets[t]) begin
            ok = 0;
            for (int k = 0; k < 500; k++) begin
                @(posedge clk); #2;
                if (int'(comm) == targets[t]) begin ok = 1; break; end
            end
            total++; if (!ok) begin bad++; $display("[TB] FAIL ack_wait_cmd[%0d] got=%0d want=%0d", t, comm, targets[t]); end
            repeat (5) @(negedge clk);
            ack_fl = 1'b1;
            @(negedge clk); ack_fl = 1'b0;
            ok = 0;
            for (int k = 0; k < 50; k++) begin
                @(posedge clk); #2;
                if (comm == 4'd0) begin ok = 1; break; end
            end
            total++; if (!ok) begin bad++; $display("[TB] FAIL ack_release[%0d] got=%0d want=0", t, comm); end
        end
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (stb_cyc.size() >= 1) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("[TB] FAIL ack_read_wait got=0 want=1"); end
        total++; if (fault !== 1'b0 || init_done !== 1'b1) begin bad++; $display("[TB] FAIL ack_status got=%b/%b want=0/1", fault, init_done); end
        total++; if (log_code.size() < 11) begin bad++; $display("[TB] FAIL ack_log_len got=%0d want=11+", log_code.size()); end
        if (log_code.size() >= 11) begin
            for (int i = 0; i < 10; i++) begin
                total++; if (log_code[i] != exp_log[i]) begin bad++; $display("[TB] FAIL ack_seq[%0d] got=%0d want=%0d", i, log_code[i], exp_log[i]); end
            end
            total++; if (log_code[10] != 8) begin bad++; $display("[TB] FAIL ack_first_read got=%0d want=8", log_code[10]); end
        end
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun();
        int prev;
        int steps;
        int step_err;
        $display("[TB] overrun counter");
        hold_read = 2000;
        clear_logs();
        total++; if (cnt_ovr !== 5'd0) begin bad++; $display("[TB] FAIL ovr_start got=%0d want=0", cnt_ovr); end
        @(negedge clk); start = 1'b1;
        prev = 0; steps = 0; step_err = 0;
        for (int k = 0; k < 60000; k++) begin
            @(posedge clk); #2;
            if (int'(cnt_ovr) == prev + 1) steps++;
            else if (int'(cnt_ovr) != prev) step_err++;
            prev = int'(cnt_ovr);
        end
        total++; if (step_err != 0) begin bad++; $display("[TB] FAIL ovr_step got=%0d bad steps want=0", step_err); end
        total++; if (steps != 31) begin bad++; $display("[TB] FAIL ovr_increments got=%0d want=31", steps); end
        total++; if (cnt_ovr !== 5'd31) begin bad++; $display("[TB] FAIL ovr_saturate got=%0d want=31", cnt_ovr); end
        total++; if (stb_cyc.size() < 2 || fault !== 1'b0) begin bad++; $display("[TB] FAIL ovr_lists got=%0d/%b want=2+/0", stb_cyc.size(), fault); end
        @(negedge clk); start = 1'b0;
        hold_read = 1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (cnt_ovr !== 5'd31) begin bad++; $display("[TB] FAIL ovr_kept_idle got=%0d want=31", cnt_ovr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        $display("[TB] reset during read");
        clear_logs();
        @(negedge clk); start = 1'b1;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (int'(comm) == exp_read[1]) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("[TB] FAIL mid_wait got=%0d want=%0d", comm, exp_read[1]); end
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (comm !== 4'd0) begin bad++; $display("[TB] FAIL mid_comm got=%0d want=0", comm); end
        total++; if (init_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_init_done got=%b want=0", init_done); end
        total++; if (cnt_ovr !== 5'd0) begin bad++; $display("[TB] FAIL mid_cnt_ovr got=%0d want=0", cnt_ovr); end
        total++; if (fault !== 1'b0 || smpl_stb !== 1'b0) begin bad++; $display("[TB] FAIL mid_flags got=%b/%b want=0/0", fault, smpl_stb); end
        @(negedge clk); rst_n = 1'b1;
        clear_logs();
        repeat (1500) @(posedge clk);
        #2;
        total++; if (log_code.size() != 0 || comm !== 4'd0) begin bad++; $display("[TB] FAIL mid_quiet got=%0d issues want=0", log_code.size()); end
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (log_code.size() >= 1) begin ok = 1; break; end
        end
        total++; if (!ok || log_code[0] != 1) begin bad++; $display("[TB] FAIL mid_restart got=%0d want=1", comm); end
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        resp_delay = 20; resp_hold = 1; hold_read = 1; ignore_code = 15;
        rst_n = 1'b0; start = 1'b0; err = 1'b0; ack_fl = 1'b0;
        stb_hi = 0;
`ifdef MPU_6050_SEQ_TEMP_EN
        exp_read = '{8, 9, 10};
`else
        exp_read = '{8, 10, 0};
`endif
        test_reset();
        test_init_and_reads();
        test_retry_fault();
        test_ack_retry();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpu_6050_sequencer.md
# mpu_6050_sequencer

Command sequencer directly upstream of the MPU-6050 top. It drives the 4-bit command input `I_COMM` and consumes the top's completion flag `O_FL` and error outputs `O_ERR`/`O_ACK_FL`. After start it runs a one-shot init list, then issues the periodic sensor read list at a fixed sample rate. Failed commands are retried; persistent failure latches a fault.

## Interface
Parameters:
- FPGA_CLK, 50_000_000: clock frequency in Hz.
- SMPL_RATE, 100: read-list start rate in Hz. Tick period is FPGA_CLK/SMPL_RATE cycles.
- TIMEOUT_CYC, 100_000: maximum cycles from issue to completion before a retry.
- MAX_RETRY, 3: retries per command before fault.
- ADDR_ROM_SZ, 4: command width.
- FL_SZ, 8: completion flag width.

Ports:
- CLK  in  1  clock.
- RST_n  in  1  reset, asynchronous, active-low.
- I_START  in  1  level enable. Rising edge starts the init list; low aborts to IDLE.
- I_FL  in  FL_SZ  completion flag from the top. Any nonzero value means the current command is done.
- I_ERR  in  1  chip-id or FSM error from the top.
- I_ACK_FL  in  1  I2C NACK flag from the top.
- O_COMM  out  ADDR_ROM_SZ  command to the top. 4'h0 is NOP.
- O_INIT_DONE  out  1  init list completed. Sticky until IDLE.
- O_SMPL_STB  out  1  one-cycle pulse when a read list completes.
- O_FAULT  out  1  retries exhausted. Sticky until I_START is low or reset.
- O_CNT_OVR  out  5  count of sample ticks that arrived while the read list was still busy. Saturates at 31.

## Operation
- Command codes:
  - Init list: 1 WHO_AM_I, 2 PWR_MGMT_1 wake, 3 SMPLRT_DIV, 4 CONFIG, 5 GYRO_CONFIG, 6 ACCEL_CONFIG.
  - Read list: 8 ACCEL, 9 TEMP, 10 GYRO.
- Handshake is 4-phase:
  - The sequencer drives a code and holds it until I_FL != 0.
  - It then drives NOP and waits for I_FL == 0.
  - Only then does it advance to the next command.
- States:
  - IDLE: O_COMM=0. Goes to ISSUE (init index 0) on an I_START rising edge.
  - ISSUE: latches the code from the list index into O_COMM, clears the timeout counter, goes to WAIT_DONE.
  - WAIT_DONE:
    - I_FL != 0 with no error → RELEASE.
    - Rising edge of I_ERR or I_ACK_FL, or timeout reaching TIMEOUT_CYC → RETRY.
  - RELEASE: O_COMM=0. When I_FL == 0 → NEXT.
  - NEXT:
    - Increments the index.
    - End of init list → set O_INIT_DONE, go to WAIT_TICK.
    - End of read list → pulse O_SMPL_STB, go to WAIT_TICK.
    - Otherwise → ISSUE.
  - WAIT_TICK: tick pending → clear pending, read index 0, ISSUE.
  - RETRY:
    - O_COMM=0. Waits for I_FL == 0, then increments the retry counter.
    - Counter > MAX_RETRY → FAULT. Otherwise → ISSUE with the same index.
    - The retry counter clears on every NEXT.
  - FAULT: O_COMM=0, O_FAULT=1. Leaves only when I_START is low (→ IDLE).
- From any state, I_START low → IDLE next cycle. IDLE clears O_INIT_DONE, O_FAULT, the indices and tick pending. O_CNT_OVR is kept.
- Sample timer:
  - Free-runs only once O_INIT_DONE=1 and generates a tick every period.
  - Tick in WAIT_TICK → starts a read list.
  - Tick while the read list is active → sets pending. If pending is already set, O_CNT_OVR increments instead.
- Error inputs are edge-detected through a 2-flop register, so stuck-high errors cause exactly one retry.

## Timing
- Reset values: O_COMM=0, O_INIT_DONE=0, O_SMPL_STB=0, O_FAULT=0, O_CNT_OVR=0, state IDLE, timer 0.
- All outputs are registered.
- I_START rising edge at cycle n → O_COMM=1 at cycle n+2: one cycle for edge detect, one for ISSUE.
- I_FL seen nonzero at cycle n → O_COMM=0 at n+1.
- I_FL seen zero in RELEASE at cycle m → next code at m+3 (NEXT, ISSUE, register).
- Last RELEASE of a read list → O_SMPL_STB at the following cycle (NEXT).
- Timeout fires when the counter equals TIMEOUT_CYC-1 in WAIT_DONE.
- I_FL nonzero and an error edge in the same cycle → the error wins (RETRY).
- Tick and read-list completion in the same cycle → the tick sets pending, and the next read starts right after NEXT. No overrun is counted.

## Configuration
- MPU_6050_SEQ_TEMP_EN defined: the read list is 8, 9, 10.
- Not defined: the read list is 8, 10, and code 9 is never issued.
- The init list is identical in both builds.

## Structure
- Package mpu_6050_pkg holds:
  - command code localparams (CMD_NOP, CMD_WHO_AM_I … CMD_GYRO);
  - init and read list lengths;
  - the state enum.
- Sub-module mpu_smpl_timer (CLK, RST_n, I_EN, O_TICK) holds the sample-period counter and its one-cycle tick.
- The list ROMs, the FSM, the timeout counter, the retry counter and the overrun counter stay in the top.

## Test plan
All scenarios use FPGA_CLK=1_000_000, SMPL_RATE=1000 (1000-cycle period), TIMEOUT_CYC=100, MAX_RETRY=3.

1. Start, with a responder that returns I_FL=8'h01 after 20 cycles and 0 after NOP → O_COMM sequence 1,2,3,4,5,6, then O_INIT_DONE=1, then reads 8,9,10 and O_SMPL_STB, repeating every 1000 cycles.
2. Without MPU_6050_SEQ_TEMP_EN → each read list is 8,10, with one O_SMPL_STB per list.
3. Responder never answers command 2 → four issues of 2 spaced by TIMEOUT_CYC plus release, then O_FAULT=1 and O_COMM=0. Dropping I_START → IDLE with O_FAULT=0.
4. I_ACK_FL pulse during command 3 → command 3 reissued once, then the sequence continues. Retry counter resets at command 4.
5. Responder delay 1500 cycles per read → O_CNT_OVR increments once per extra tick and saturates at 31.
6. RST_n low during WAIT_DONE of command 9 → all outputs 0 immediately. After release, nothing happens until a new I_START rising edge.
